// File: rtl/sw_debounce_sync.sv
// rtl/sw_debounce_sync.sv - per-bit synchronizer and debounce FSM for raw slide switches
// Emits debounced level plus registered rise/fall pulses and a combined change strobe.
module sw_debounce_sync #(
    parameter int WIDTH       = 2,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_MAX     = 500000
) (
    input  logic             MAX10_CLK1_50,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_change
);

    localparam int CNT_W = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0]                  sync_s;
    state_t                            state_q [WIDTH];
    state_t                            state_d [WIDTH];
    logic [CNT_W-1:0]                  cnt_q   [WIDTH];
    logic [CNT_W-1:0]                  cnt_d   [WIDTH];
    logic [WIDTH-1:0]                  db_q, db_d;
    logic [WIDTH-1:0]                  rise_q, rise_d;
    logic [WIDTH-1:0]                  fall_q, fall_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], sw_raw};
        sync_s = sync_q[SYNC_STAGES-1];
        db_d   = db_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_STABLE: begin
                    if (sync_s[i] != db_q[i]) begin
                        state_d[i] = ST_COUNTING;
                        cnt_d[i]   = '0;
                    end
                end
                default: begin
                    // Any return to the accepted level restarts the stability window.
                    if (sync_s[i] == db_q[i]) begin
                        state_d[i] = ST_STABLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        db_d[i]    = sync_s[i];
                        rise_d[i]  = sync_s[i];
                        fall_d[i]  = ~sync_s[i];
                        state_d[i] = ST_STABLE;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge MAX10_CLK1_50) begin
        if (reset) begin
            sync_q <= '0;
            db_q   <= '0;
            rise_q <= '0;
            fall_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= ST_STABLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync_q <= sync_d;
            db_q   <= db_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign sw_db     = db_q;
    assign sw_rise   = rise_q;
    assign sw_fall   = fall_q;
    assign sw_change = |(rise_q | fall_q);

endmodule

// File: tb/tb_sw_debounce_sync.sv
// tb/tb_sw_debounce_sync.sv - scoreboard bench for sw_debounce_sync with a run-length reference model
module tb_sw_debounce_sync;

    localparam int W  = 2;
    localparam int SS = 2;
    localparam int CM = 4;
    localparam int LAT = SS + CM + 1;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] sw_raw = '0;
    logic [W-1:0] sw_db, sw_rise, sw_fall;
    logic         sw_change;

    typedef struct packed {
        logic [W-1:0] db;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic         change;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] m_line[$];
    logic [W-1:0] m_db = '0;
    int           m_run[W];
    int           n_checks = 0;
    int           n_fail = 0;

    sw_debounce_sync #(.WIDTH(W), .SYNC_STAGES(SS), .CNT_MAX(CM)) dut (
        .MAX10_CLK1_50(clk),
        .reset(reset),
        .sw_raw(sw_raw),
        .sw_db(sw_db),
        .sw_rise(sw_rise),
        .sw_fall(sw_fall),
        .sw_change(sw_change)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // The synchronized value is the raw input seen SS edges earlier; a level is
    // accepted once it has differed from sw_db on CM+1 consecutive edges.
    task automatic model_edge(input logic [W-1:0] raw, input logic rst);
        exp_t e;
        logic [W-1:0] s;
        e = '0;
        if (rst) begin
            m_line.delete();
            for (int k = 0; k < SS; k++) m_line.push_back('0);
            m_db = '0;
            for (int i = 0; i < W; i++) m_run[i] = 0;
        end else begin
            s = m_line.pop_back();
            m_line.push_front(raw);
            for (int i = 0; i < W; i++) begin
                if (s[i] != m_db[i]) m_run[i] = m_run[i] + 1;
                else m_run[i] = 0;
                if (m_run[i] == CM + 1) begin
                    m_db[i]   = s[i];
                    e.rise[i] = s[i];
                    e.fall[i] = ~s[i];
                    m_run[i]  = 0;
                end
            end
            e.db     = m_db;
            e.change = |(e.rise | e.fall);
        end
        exp_q.push_back(e);
    endtask

    task automatic step(input logic [W-1:0] raw, input logic rst);
        @(negedge clk);
        sw_raw = raw;
        reset  = rst;
        model_edge(raw, rst);
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_db", 32'(sw_db), 32'(e.db));
            check("sb_rise", 32'(sw_rise), 32'(e.rise));
            check("sb_fall", 32'(sw_fall), 32'(e.fall));
            check("sb_change", 32'(sw_change), 32'(e.change));
        end
    end

    initial begin
        int k;
        logic [W-1:0] raw;
        logic [W-1:0] db_hold;

        // Reset with switches high, then full-latency acceptance.
        repeat (3) step(2'b11, 1'b1);
        check("reset_db", 32'(sw_db), 32'h0);
        for (int n = 1; n <= LAT; n++) begin
            step(2'b11, 1'b0);
            if (n < LAT) check("pre_accept_db", 32'(sw_db), 32'h0);
        end
        check("accept_db", 32'(sw_db), 32'h3);
        check("accept_rise", 32'(sw_rise), 32'h3);
        check("accept_change", 32'(sw_change), 32'h1);
        step(2'b11, 1'b0);
        check("rise_one_cycle", 32'(sw_rise), 32'h0);
        repeat (10) step(2'b00, 1'b0);

        // Single bit rise then fall latency.
        for (k = 1; k <= 20; k++) begin
            step(2'b01, 1'b0);
            if (sw_rise[0]) break;
        end
        check("rise0_latency", 32'(k), 32'(LAT));
        check("rise0_no_fall", 32'(sw_fall), 32'h0);
        repeat (5) step(2'b01, 1'b0);
        for (k = 1; k <= 20; k++) begin
            step(2'b00, 1'b0);
            if (sw_fall[0]) break;
        end
        check("fall0_latency", 32'(k), 32'(LAT));

        // Short bounce never accepted.
        repeat (3) step(2'b01, 1'b0);
        repeat (10) step(2'b00, 1'b0);
        check("bounce_db", 32'(sw_db), 32'h0);

        // Opposite transitions on both bits in the same edge.
        repeat (10) step(2'b10, 1'b0);
        for (k = 1; k <= 20; k++) begin
            step(2'b01, 1'b0);
            if (sw_change) break;
        end
        check("swap_latency", 32'(k), 32'(LAT));
        check("swap_rise", 32'(sw_rise), 32'h1);
        check("swap_fall", 32'(sw_fall), 32'h2);
        step(2'b01, 1'b0);
        check("swap_change_once", 32'(sw_change), 32'h0);
        check("swap_db", 32'(sw_db), 32'h1);

        // Reset in the middle of a count restarts full latency.
        repeat (10) step(2'b00, 1'b0);
        repeat (5) step(2'b10, 1'b0);
        step(2'b10, 1'b1);
        for (k = 1; k <= 20; k++) begin
            step(2'b10, 1'b0);
            if (sw_rise[1]) break;
        end
        check("reset_mid_latency", 32'(k), 32'(LAT));
        check("reset_mid_db", 32'(sw_db), 32'h2);

        // Fast toggling never propagates.
        db_hold = sw_db;
        for (int n = 0; n < 100; n++) step((n % 2) ? 2'b01 : 2'b10, 1'b0);
        check("toggle_db_const", 32'(sw_db), 32'(db_hold));

        // Randomized holds, bursts and occasional resets.
        raw = 2'b00;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(5, 0) == 0) raw = W'($urandom);
            step(raw, $urandom_range(399, 0) == 0);
        end

        @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
